// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared defaults, bias and special-value pack helpers for the pipelined FP adder
package ahfp_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  function automatic int ext_w(int mw);
    return mw + 4;
  endfunction
  function automatic int bias(int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] zero_bits(int ew, int mw, logic s);
    return {63'd0, s} << (ew + mw);
  endfunction
  function automatic logic [63:0] inf_bits(int ew, int mw, logic s);
    return ({63'd0, s} << (ew + mw)) | (((64'd1 << ew) - 64'd1) << mw);
  endfunction
  function automatic logic [63:0] qnan_bits(int ew, int mw);
    return ((64'd1 << (ew + 1)) - 64'd1) << (mw - 1);
  endfunction
endpackage

// File: rtl/ahfp_lzc.sv
// ahfp_lzc: combinational leading-zero counter, returns W when the input is all zeros
module ahfp_lzc #(
  parameter int W = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) cnt = a[i] ? CW'(W - 1 - i) : cnt;
  end
endmodule

// File: rtl/ahfp_add_pipe.sv
// ahfp_add_pipe: four-stage round-to-nearest-even floating-point adder/subtractor with clk_en stall
module ahfp_add_pipe
  import ahfp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic                   n,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = ext_w(MAN_W);
  localparam int EW = EXP_W + 1;
  localparam int LW = $clog2(M + 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [EXP_W-1:0] FAR = EXP_W'(M - 1);
  localparam logic [EW-1:0] EMAX = {1'b0, EONES};
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));
  typedef struct packed {
    logic v; logic s; logic sub; logic [EXP_W-1:0] e; logic [M-1:0] ml; logic [M-1:0] al; logic spec; logic [W-1:0] sv;
  } s1_t;
  typedef struct packed {
    logic v; logic s; logic [EXP_W-1:0] e; logic [M:0] m; logic spec; logic [W-1:0] sv;
  } s2_t;
  typedef struct packed {
    logic v; logic s; logic uf; logic [EW-1:0] e; logic [M-1:0] m; logic spec; logic [W-1:0] sv;
  } s3_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [W-1:0] result_d, result_q;
  logic done_d, done_q;
  logic sa, sb, za, zb, na, nb, ia, ib, swap;
  logic [EXP_W-1:0] ea, eb, dexp;
  logic [MAN_W-1:0] fa, fb;
  logic [M-1:0] ms;
  logic [LW-1:0] lz;
  logic [EW-1:0] lze, e2, sh, ef;
  logic [MAN_W:0] fr;
  always_comb begin
    sa = dataa[W-1];
    sb = datab[W-1] ^ n;
    ea = dataa[W-2:MAN_W];
    eb = datab[W-2:MAN_W];
    za = ea == '0;
    zb = eb == '0;
    fa = za ? '0 : dataa[MAN_W-1:0];
    fb = zb ? '0 : datab[MAN_W-1:0];
    na = ea == EONES && fa != '0;
    nb = eb == EONES && fb != '0;
    ia = ea == EONES && fa == '0;
    ib = eb == EONES && fb == '0;
    swap = {eb, fb} > {ea, fa};
    ms = swap ? {~za, fa, 3'b000} : {~zb, fb, 3'b000};
    dexp = swap ? eb - ea : ea - eb;
    s1_d.v = start;
    s1_d.s = swap ? sb : sa;
    s1_d.sub = sa ^ sb;
    s1_d.e = swap ? eb : ea;
    s1_d.ml = swap ? {~zb, fb, 3'b000} : {~za, fa, 3'b000};
    s1_d.al = dexp >= FAR ? {{(M-1){1'b0}}, |ms}
            : (ms >> dexp) | {{(M-1){1'b0}}, |(ms & ~({M{1'b1}} << dexp))};
    s1_d.spec = na | nb | ia | ib;
    s1_d.sv = (na | nb | (ia & ib & (sa ^ sb))) ? QNAN : W'(inf_bits(EXP_W, MAN_W, ia ? sa : sb));
  end
  always_comb begin
    s2_d.v = s1_q.v;
    s2_d.e = s1_q.e;
    s2_d.m = s1_q.sub ? {1'b0, s1_q.ml} - {1'b0, s1_q.al} : {1'b0, s1_q.ml} + {1'b0, s1_q.al};
    s2_d.s = (s1_q.sub && s2_d.m == '0) ? 1'b0 : s1_q.s;
    s2_d.spec = s1_q.spec;
    s2_d.sv = s1_q.sv;
  end
  ahfp_lzc #(.W(M)) u_lzc (.a(s2_q.m[M-1:0]), .cnt(lz));
  always_comb begin
    e2 = {1'b0, s2_q.e};
    lze = EW'(lz);
    sh = lze < e2 ? lze : e2 - 1'b1;
    s3_d.v = s2_q.v;
    s3_d.s = s2_q.s;
    s3_d.uf = !s2_q.m[M] && lze >= e2 && s2_q.m != '0;
    s3_d.e = s2_q.m[M] ? e2 + 1'b1 : e2 - sh;
    s3_d.m = s2_q.m[M] ? {s2_q.m[M:2], s2_q.m[1] | s2_q.m[0]} : s2_q.m[M-1:0] << sh;
    s3_d.spec = s2_q.spec;
    s3_d.sv = s2_q.sv;
  end
  always_comb begin
    fr = {1'b0, s3_q.m[M-2:3]} + {{MAN_W{1'b0}}, s3_q.m[2] & (s3_q.m[1] | s3_q.m[0] | s3_q.m[3])};
    ef = s3_q.e + {{(EW-1){1'b0}}, fr[MAN_W]};
    result_d = s3_q.spec ? s3_q.sv
             : s3_q.uf ? '0
             : !s3_q.m[M-1] ? W'(zero_bits(EXP_W, MAN_W, s3_q.s))
             : ef >= EMAX ? W'(inf_bits(EXP_W, MAN_W, s3_q.s))
             : {s3_q.s, ef[EXP_W-1:0], fr[MAN_W-1:0]};
    done_d = s3_q.v;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
    end else if (clk_en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign result = result_q;
  assign done = done_q;
endmodule

// File: tb/tb_ahfp_add_pipe.sv
// tb_ahfp_add_pipe: scoreboard bench for ahfp_add_pipe against a real-arithmetic reference
module tb_ahfp_add_pipe;
  logic clk = 1'b0;
  logic reset_n, clk_en, start, n, done;
  logic [31:0] dataa, datab, result;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int lat, p0;
  logic [31:0] expq[$];
  ahfp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done)
  );
  always #5 clk = ~clk;
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00) d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = x[22:0] != 0 ? 64'h7FF8000000000000 : {x[31], 11'h7FF, 52'd0};
    else d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return d[51:0] != 0 ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
    if (d[62:0] == 0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return 32'd0;
    m = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic nn);
    return r2f(f2r(a) + f2r({b[31] ^ nn, b[30:0]}));
  endfunction
  function automatic logic [31:0] rnd_f();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) x[30:23] = 8'hFF;
    else if (k == 1) x[30:23] = 8'h00;
    else if (k == 2) x[30:23] = 8'hFE;
    else if (k == 3) x[30:23] = 8'h01;
    else x[30:23] = 8'($urandom_range(100, 154));
    return x;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic nn, input logic [31:0] want);
    dataa = a;
    datab = b;
    n = nn;
    start = 1'b1;
    if (clk_en) expq.push_back(want);
    @(negedge clk);
  endtask
  task automatic issue_rnd();
    logic [31:0] a, b;
    logic nn;
    int k;
    a = rnd_f();
    b = rnd_f();
    nn = 1'($urandom);
    k = $urandom_range(0, 3);
    if (k == 0) b[30:23] = a[30:23];
    if (k == 1) begin
      b[30:0] = a[30:0];
      b[3:0] = 4'($urandom);
    end
    issue(a, b, nn, ref_add(a, b, nn));
  endtask
  task automatic drain();
    int k;
    start = 1'b0;
    k = 0;
    while (expq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() != 0) check("drain_timeout", 32'(expq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic en_seen, pd;
    logic [31:0] pr;
    pd = 1'b0;
    pr = '0;
    forever begin
      @(posedge clk);
      en_seen = clk_en;
      @(negedge clk);
      if (!en_seen) begin
        check("stall_done", {31'd0, done}, {31'd0, pd});
        check("stall_result", result, pr);
      end else if (done) begin
        pulses++;
        if (expq.size() == 0) check("spurious_done", {31'd0, done}, 32'd0);
        else check("result", result, expq.pop_front());
      end
      pd = done;
      pr = result;
    end
  end
  initial begin
    reset_n = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    n = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset_n = 1'b1;
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    issue(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000);
    issue(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    issue(32'h00000001, 32'h00000000, 1'b0, 32'h00000000);
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    issue(32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    issue(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
    issue(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    drain();
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
      end
      issue_rnd();
    end
    drain();
    check("stream_pulses", 32'(pulses - p0), 32'd8);
    for (int i = 0; i < 300; i++) begin
      clk_en = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 3) != 0) issue_rnd();
      else begin
        start = 1'b0;
        @(negedge clk);
      end
    end
    clk_en = 1'b1;
    drain();
    check("queue_empty", 32'(expq.size()), 32'd0);
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    drain();
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
    reset_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    expq.delete();
    reset_n = 1'b1;
    p0 = pulses;
    repeat (10) @(negedge clk);
    check("post_reset_pulses", 32'(pulses - p0), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
